// File: rtl/multi_com_tracker.sv
// multi_com_tracker
//   Per-channel centre-of-mass tracker for NUM_CH threshold masks. Every cycle each
//   channel whose mask bit is set (qualified by valid_in) adds the pixel's x/y to its
//   sums and bumps its pixel count. On tabulate_in the sums are snapshotted and a
//   single time-shared restoring divider walks the channels, producing x/y centroids
//   for channels with at least MIN_COUNT pixels.
// Ports
//   clk_in, rst_n_in  : clock, asynchronous active-low reset
//   x_in, y_in        : coordinates of the current pixel
//   valid_in, mask_in : pixel qualifier and per-channel mask hit
//   tabulate_in       : one-cycle frame-boundary strobe
//   x_com_out/y_com_out : packed centroids, channel c at [c*W +: W]
//   com_valid_out     : one-cycle per-channel update pulse
//   present_out       : channel met MIN_COUNT in the last tabulated frame
//   busy_out          : divider sequencing in progress
//   overrun_out       : pulse when tabulate_in arrives while busy
module multi_com_tracker #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned H_WIDTH   = 11,
    parameter int unsigned V_WIDTH   = 10,
    parameter int unsigned CNT_WIDTH = 17,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [H_WIDTH-1:0]          x_in,
    input  logic [V_WIDTH-1:0]          y_in,
    input  logic                        valid_in,
    input  logic [NUM_CH-1:0]           mask_in,
    input  logic                        tabulate_in,
    output logic [NUM_CH*H_WIDTH-1:0]   x_com_out,
    output logic [NUM_CH*V_WIDTH-1:0]   y_com_out,
    output logic [NUM_CH-1:0]           com_valid_out,
    output logic [NUM_CH-1:0]           present_out,
    output logic                        busy_out,
    output logic                        overrun_out
);

    localparam int unsigned MW  = (H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH;
    localparam int unsigned DW  = MW + CNT_WIDTH;
    localparam int unsigned SXW = H_WIDTH + CNT_WIDTH;
    localparam int unsigned SYW = V_WIDTH + CNT_WIDTH;
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BW  = $clog2(DW);

    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_COUNT);
    localparam logic [CHW-1:0]       LAST_CH = CHW'(NUM_CH - 1);
    localparam logic [BW-1:0]        LAST_BIT = BW'(DW - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CHK  = 3'd1;
    localparam logic [2:0] S_DIVX = 3'd2;
    localparam logic [2:0] S_DIVY = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_NXT  = 3'd5;

    // Live accumulators and frame snapshots
    logic [SXW-1:0]       r_sx    [NUM_CH];
    logic [SYW-1:0]       r_sy    [NUM_CH];
    logic [CNT_WIDTH-1:0] r_cnt   [NUM_CH];
    logic [SXW-1:0]       r_sh_sx [NUM_CH];
    logic [SYW-1:0]       r_sh_sy [NUM_CH];
    logic [CNT_WIDTH-1:0] r_sh_cnt[NUM_CH];

    logic [2:0]                 r_state;
    logic [CHW-1:0]             r_ch;
    logic [BW-1:0]              r_bit;
    logic [DW-1:0]              r_quo;
    logic [CNT_WIDTH-1:0]       r_rem;
    logic [H_WIDTH-1:0]         r_xq;
    logic                       r_busy;
    logic                       r_overrun;
    logic [NUM_CH-1:0]          r_com_valid;
    logic [NUM_CH-1:0]          r_present;
    logic [NUM_CH*H_WIDTH-1:0]  r_x_com;
    logic [NUM_CH*V_WIDTH-1:0]  r_y_com;

    logic [NUM_CH-1:0]    w_hit;
    logic [CNT_WIDTH-1:0] w_div;
    logic [CNT_WIDTH:0]   w_shift;
    logic [CNT_WIDTH-1:0] w_diff;
    logic                 w_ge;
    logic [CNT_WIDTH-1:0] w_rem_next;
    logic [DW-1:0]        w_quo_next;

    assign w_hit = {NUM_CH{valid_in}} & mask_in;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_div      = r_sh_cnt[r_ch];
        w_shift    = {r_rem, r_quo[DW-1]};
        w_ge       = (w_shift >= {1'b0, w_div});
        // Remainder stays below the divisor, so the low CNT_WIDTH bits hold the exact difference.
        w_diff     = w_shift[CNT_WIDTH-1:0] - w_div;
        w_rem_next = w_ge ? w_diff : w_shift[CNT_WIDTH-1:0];
        w_quo_next = {r_quo[DW-2:0], w_ge};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sx[c]     <= '0;
                r_sy[c]     <= '0;
                r_cnt[c]    <= '0;
                r_sh_sx[c]  <= '0;
                r_sh_sy[c]  <= '0;
                r_sh_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (tabulate_in) begin
                    // A pixel on the tabulate cycle belongs to the new frame.
                    r_sx[c]  <= w_hit[c] ? SXW'(x_in) : '0;
                    r_sy[c]  <= w_hit[c] ? SYW'(y_in) : '0;
                    r_cnt[c] <= CNT_WIDTH'(w_hit[c]);
                    // Snapshot only when the divider is free; otherwise the frame is dropped.
                    if (!r_busy) begin
                        r_sh_sx[c]  <= r_sx[c];
                        r_sh_sy[c]  <= r_sy[c];
                        r_sh_cnt[c] <= r_cnt[c];
                    end
                end else if (w_hit[c]) begin
                    r_sx[c] <= r_sx[c] + SXW'(x_in);
                    r_sy[c] <= r_sy[c] + SYW'(y_in);
                    if (r_cnt[c] != '1) begin
                        r_cnt[c] <= r_cnt[c] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_bit       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_xq        <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_com_valid <= '0;
            r_present   <= '0;
            r_x_com     <= '0;
            r_y_com     <= '0;
        end else begin
            r_com_valid <= '0;
            r_overrun   <= tabulate_in & r_busy;
            case (r_state)
                S_IDLE: begin
                    if (tabulate_in) begin
                        r_state <= S_CHK;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CHK: begin
                    if (r_sh_cnt[r_ch] >= MIN_CNT) begin
                        r_quo   <= DW'(r_sh_sx[r_ch]);
                        r_rem   <= '0;
                        r_bit   <= '0;
                        r_state <= S_DIVX;
                    end else begin
                        r_present[r_ch] <= 1'b0;
                        r_state         <= S_NXT;
                    end
                end
                S_DIVX: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_bit <= r_bit + BW'(1);
                    if (r_bit == LAST_BIT) begin
                        r_xq    <= w_quo_next[H_WIDTH-1:0];
                        r_quo   <= DW'(r_sh_sy[r_ch]);
                        r_rem   <= '0;
                        r_bit   <= '0;
                        r_state <= S_DIVY;
                    end
                end
                S_DIVY: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_bit <= r_bit + BW'(1);
                    if (r_bit == LAST_BIT) begin
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_x_com[r_ch*H_WIDTH +: H_WIDTH] <= r_xq;
                    r_y_com[r_ch*V_WIDTH +: V_WIDTH] <= r_quo[V_WIDTH-1:0];
                    r_present[r_ch]   <= 1'b1;
                    r_com_valid[r_ch] <= 1'b1;
                    r_state           <= S_NXT;
                end
                S_NXT: begin
                    if (r_ch == LAST_CH) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ch    <= r_ch + CHW'(1);
                        r_state <= S_CHK;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x_com_out     = r_x_com;
    assign y_com_out     = r_y_com;
    assign com_valid_out = r_com_valid;
    assign present_out   = r_present;
    assign busy_out      = r_busy;
    assign overrun_out   = r_overrun;

endmodule
